// File: rtl/return_address_stack_ctrl.sv
// Circular return-address stack with per-instruction checkpoint and mispredict restore.
// Optional macro RAS_TOS_REPAIR_EN: checkpoint also carries the TOS value, and restore rewrites that entry.
module return_address_stack_ctrl #(
    parameter  int XLEN   = 32,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1),
`ifdef RAS_TOS_REPAIR_EN
    localparam int CKPT_W = PTR_W + CNT_W + XLEN
`else
    localparam int CKPT_W = PTR_W + CNT_W
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_push,
    input  logic [XLEN-1:0]   i_push_addr,
    input  logic              i_pop,
    input  logic              i_restore,
    input  logic [CKPT_W-1:0] i_restore_ckpt,
    output logic [XLEN-1:0]   o_predicted_target,
    output logic              o_valid,
    output logic [CKPT_W-1:0] o_ckpt
);

    logic [XLEN-1:0]  r_entry [DEPTH];
    logic [PTR_W-1:0] r_tos_ptr;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  w_tos_value;
    logic [PTR_W-1:0] w_ck_ptr;
    logic [CNT_W-1:0] w_ck_cnt;
    logic [PTR_W-1:0] w_nxt_ptr;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic [XLEN-1:0]  w_wr_data;

    function automatic logic [CNT_W-1:0] f_cnt_inc_sat(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(DEPTH)) ? c : c + CNT_W'(1);
    endfunction

    assign w_tos_value        = r_entry[r_tos_ptr];
    assign o_valid            = (r_count != '0);
    assign o_predicted_target = o_valid ? w_tos_value : '0;

    assign w_ck_ptr = i_restore_ckpt[CKPT_W-1 -: PTR_W];
    assign w_ck_cnt = i_restore_ckpt[CKPT_W-PTR_W-1 -: CNT_W];

`ifdef RAS_TOS_REPAIR_EN
    assign o_ckpt = {r_tos_ptr, r_count, w_tos_value};
`else
    assign o_ckpt = {r_tos_ptr, r_count};
`endif

    // Restore beats stall, stall beats push/pop; a full push overwrites the oldest entry.
    always_comb begin
        w_nxt_ptr = r_tos_ptr;
        w_nxt_cnt = r_count;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_tos_ptr;
        w_wr_data = i_push_addr;
        if (i_restore) begin
            w_nxt_ptr = w_ck_ptr;
            w_nxt_cnt = w_ck_cnt;
`ifdef RAS_TOS_REPAIR_EN
            w_wr_en   = 1'b1;
            w_wr_idx  = w_ck_ptr;
            w_wr_data = i_restore_ckpt[XLEN-1:0];
`endif
        end else if (!i_stall) begin
            if (i_push && i_pop) begin
                // Coroutine swap: replace TOS in place; an empty stack gains one entry.
                w_wr_en   = 1'b1;
                w_wr_idx  = r_tos_ptr;
                w_nxt_cnt = (r_count == '0) ? CNT_W'(1) : r_count;
            end else if (i_push) begin
                w_nxt_ptr = r_tos_ptr + PTR_W'(1);
                w_wr_en   = 1'b1;
                w_wr_idx  = r_tos_ptr + PTR_W'(1);
                w_nxt_cnt = f_cnt_inc_sat(r_count);
            end else if (i_pop && (r_count != '0)) begin
                w_nxt_ptr = r_tos_ptr - PTR_W'(1);
                w_nxt_cnt = r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tos_ptr <= '0;
            r_count   <= '0;
            for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
        end else begin
            r_tos_ptr <= w_nxt_ptr;
            r_count   <= w_nxt_cnt;
            if (w_wr_en) r_entry[w_wr_idx] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_return_address_stack_ctrl.sv
// Directed table-driven bench for return_address_stack_ctrl (XLEN=32, DEPTH=8).
module tb_return_address_stack_ctrl;

    localparam int XLEN  = 32;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;
`ifdef RAS_TOS_REPAIR_EN
    localparam int CKPT_W = PTR_W + CNT_W + XLEN;
`else
    localparam int CKPT_W = PTR_W + CNT_W;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_stall = 1'b0, i_push = 1'b0, i_pop = 1'b0, i_restore = 1'b0;
    logic [XLEN-1:0]   i_push_addr = '0;
    logic [CKPT_W-1:0] i_restore_ckpt = '0;
    logic [XLEN-1:0]   o_predicted_target;
    logic              o_valid;
    logic [CKPT_W-1:0] o_ckpt;

    int total = 0;
    int bad   = 0;

    return_address_stack_ctrl #(.XLEN(XLEN), .DEPTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_push(i_push),
        .i_push_addr(i_push_addr), .i_pop(i_pop), .i_restore(i_restore),
        .i_restore_ckpt(i_restore_ckpt), .o_predicted_target(o_predicted_target),
        .o_valid(o_valid), .o_ckpt(o_ckpt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        stall, push, pop, restore;
        logic [31:0] addr;
        logic [2:0]  ck_ptr;
        logic [3:0]  ck_cnt;
        logic [31:0] ck_val;
        logic        exp_valid;
        logic [31:0] exp_tgt;
        logic [2:0]  exp_ptr;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CKPT_W-1:0] mk_ckpt(input logic [2:0] p, input logic [3:0] c,
                                                  input logic [31:0] v);
`ifdef RAS_TOS_REPAIR_EN
        return {p, c, v};
`else
        return {p, c};
`endif
    endfunction

    task automatic step(input logic st, input logic pu, input logic po, input logic re,
                        input logic [31:0] addr, input logic [CKPT_W-1:0] ck);
        i_stall = st; i_push = pu; i_pop = po; i_restore = re;
        i_push_addr = addr; i_restore_ckpt = ck;
        @(posedge i_clk);
        #1;
        i_stall = 0; i_push = 0; i_pop = 0; i_restore = 0;
        i_push_addr = '0; i_restore_ckpt = '0;
    endtask

    task automatic chk_state(input string name, input logic v, input logic [31:0] tgt,
                             input logic [2:0] p, input logic [3:0] c);
        chk({name, "_valid"}, 32'(o_valid), 32'(v));
        chk({name, "_tgt"}, o_predicted_target, tgt);
        chk({name, "_ptr"}, 32'(o_ckpt[CKPT_W-1 -: PTR_W]), 32'(p));
        chk({name, "_cnt"}, 32'(o_ckpt[CKPT_W-PTR_W-1 -: CNT_W]), 32'(c));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        logic [CKPT_W-1:0] saved;
        //         st  pu  po  re  addr       ckp ckc ckv         v  tgt        p  c
        vecs[0]  = '{0, 1, 0, 0, 32'h100, 0, 0, 0,           1, 32'h100, 1, 1};
        vecs[1]  = '{0, 1, 0, 0, 32'h200, 0, 0, 0,           1, 32'h200, 2, 2};
        vecs[2]  = '{0, 1, 0, 0, 32'h300, 0, 0, 0,           1, 32'h300, 3, 3};
        vecs[3]  = '{0, 0, 1, 0, 32'h0,   0, 0, 0,           1, 32'h200, 2, 2};
        vecs[4]  = '{0, 0, 1, 0, 32'h0,   0, 0, 0,           1, 32'h100, 1, 1};
        vecs[5]  = '{0, 0, 1, 0, 32'h0,   0, 0, 0,           0, 32'h0,   0, 0};
        vecs[6]  = '{0, 0, 1, 0, 32'h0,   0, 0, 0,           0, 32'h0,   0, 0};
        vecs[7]  = '{0, 1, 0, 0, 32'h40,  0, 0, 0,           1, 32'h40,  1, 1};
        vecs[8]  = '{0, 1, 1, 0, 32'h80,  0, 0, 0,           1, 32'h80,  1, 1};
        vecs[9]  = '{1, 1, 0, 0, 32'h99,  0, 0, 0,           1, 32'h80,  1, 1};
        vecs[10] = '{1, 1, 1, 0, 32'h99,  0, 0, 0,           1, 32'h80,  1, 1};
        vecs[11] = '{0, 1, 0, 1, 32'h55,  0, 0, 0,           0, 32'h0,   0, 0};
        vecs[12] = '{0, 1, 1, 0, 32'h77,  0, 0, 0,           1, 32'h77,  0, 1};
        vecs[13] = '{0, 0, 0, 1, 32'h0,   0, 1, 32'h77,      1, 32'h77,  0, 1};

        #2;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_tgt", o_predicted_target, 32'd0);
        chk("rst_ckpt", 32'(o_ckpt == '0), 32'd1);
        do_reset();
        chk_state("idle", 0, 32'h0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].stall, vecs[i].push, vecs[i].pop, vecs[i].restore, vecs[i].addr,
                 mk_ckpt(vecs[i].ck_ptr, vecs[i].ck_cnt, vecs[i].ck_val));
            chk_state($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_tgt,
                      vecs[i].exp_ptr, vecs[i].exp_cnt);
        end

        // Overflow: nine pushes wrap and drop 0x10.
        do_reset();
        for (int k = 1; k <= 9; k++) step(0, 1, 0, 0, 32'(k * 16), '0);
        chk_state("full", 1, 32'h90, 1, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_tgt", k), o_predicted_target, 32'(32'h90 - k * 16));
            step(0, 0, 1, 0, '0, '0);
        end
        chk_state("drained", 0, 32'h0, 1, 0);
        step(0, 0, 1, 0, '0, '0);
        chk_state("underflow", 0, 32'h0, 1, 0);

        // Reset asserted in the middle of a cycle with a push pending.
        step(0, 1, 0, 0, 32'h123, '0);
        step(0, 1, 0, 0, 32'h456, '0);
        chk_state("pre_rst", 1, 32'h456, 3, 2);
        i_push = 1'b1; i_push_addr = 32'h789;
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_tgt", o_predicted_target, 32'd0);
        chk("midrst_ckpt", 32'(o_ckpt == '0), 32'd1);
        i_push = 1'b0; i_push_addr = '0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        chk_state("post_rst", 0, 32'h0, 0, 0);

        // Wrong-path pop+push clobbers TOS; restore from the saved checkpoint.
        step(0, 1, 0, 0, 32'hA0, '0);
        saved = o_ckpt;
        chk("saved_ptrcnt", 32'(saved[CKPT_W-1 -: 7]), 32'({3'd1, 4'd1}));
        step(0, 0, 1, 0, '0, '0);
        chk_state("wrong_pop", 0, 32'h0, 0, 0);
        step(0, 1, 0, 0, 32'hBB, '0);
        chk_state("wrong_push", 1, 32'hBB, 1, 1);
        step(0, 1, 1, 1, 32'hCC, saved);
`ifdef RAS_TOS_REPAIR_EN
        chk_state("repair", 1, 32'hA0, 1, 1);
`else
        chk_state("repair", 1, 32'hBB, 1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
